// File: rtl/usb_ep0_descriptor_streamer.sv
// rtl/usb_ep0_descriptor_streamer.sv - EP0 control-IN data stage: descriptor ROM to IN buffer packetiser
// Handles ACK/retry handshakes, DATA0/1 toggling and the trailing zero-length packet.
module usb_ep0_descriptor_streamer #(
  parameter int MAX_PACKET_SIZE = 64,
  parameter int ROM_ADDR_W      = 9
) (
  input  logic                  clk48,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ROM_ADDR_W-1:0] base_addr,
  input  logic [15:0]           desc_len,
  input  logic [15:0]           w_length,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  in_valid,
  output logic [7:0]            in_data,
  output logic                  in_last,
  output logic                  in_zlp,
  input  logic                  in_ready,
  input  logic                  pkt_ack,
  input  logic                  pkt_retry,
  output logic                  data_toggle,
  output logic                  busy,
  output logic                  done
);

  localparam int          MPS_W = $clog2(MAX_PACKET_SIZE);
  localparam logic [15:0] MPS16 = 16'(MAX_PACKET_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_ZLP,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ROM_ADDR_W-1:0] base_q, base_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [15:0]           pkt_base_q, pkt_base_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic [15:0]           rd_off_q, rd_off_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_last_q, rd_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [7:0]            skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_zlp_q, out_zlp_d;
  logic                  toggle_q, toggle_d;
  logic                  zlp_needed_q, zlp_needed_d;
  logic                  zlp_pkt_q, zlp_pkt_d;

  logic [15:0] total;
  logic [15:0] start_len;
  logic [15:0] pkt_end;
  logic [15:0] rem_after;
  logic [15:0] next_len;
  logic [1:0]  occ;
  logic        pop;
  logic        streaming;
  logic        can_issue;

  assign total     = (desc_len < w_length) ? desc_len : w_length;
  assign start_len = (total < MPS16) ? total : MPS16;
  assign pkt_end   = pkt_base_q + pkt_len_q;
  assign rem_after = remaining_q - pkt_len_q;
  assign next_len  = (rem_after < MPS16) ? rem_after : MPS16;
  assign pop       = out_valid_q & in_ready;
  assign streaming = (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
  // A read may only be issued if its byte is guaranteed a slot (output or skid) when it lands.
  assign can_issue = streaming && (rd_off_q < pkt_end) && (occ <= (2'd1 + {1'b0, pop}));

  // The first byte is addressed straight from base_addr so it is on the bus two cycles after start.
  assign rom_addr = (state_q == ST_IDLE && start && !abort) ? base_addr
                                                             : base_q + ROM_ADDR_W'(rd_off_q);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    remaining_d  = remaining_q;
    pkt_base_d   = pkt_base_q;
    pkt_len_d    = pkt_len_q;
    rd_off_d     = rd_off_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = rd_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_zlp_d    = out_zlp_q;
    toggle_d     = toggle_q;
    zlp_needed_d = zlp_needed_q;
    zlp_pkt_d    = zlp_pkt_q;

    if (streaming) begin
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          out_last_d   = skid_last_q;
          skid_valid_d = rd_pend_q;
          skid_data_d  = rom_data;
          skid_last_d  = rd_last_q;
        end else if (rd_pend_q) begin
          out_valid_d = 1'b1;
          out_data_d  = rom_data;
          out_last_d  = rd_last_q;
        end else begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end else if (rd_pend_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = rom_data;
        skid_last_d  = rd_last_q;
      end
      if (can_issue) begin
        rd_pend_d = 1'b1;
        rd_last_d = (rd_off_q == pkt_end - 16'd1);
        rd_off_d  = rd_off_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          remaining_d  = total;
          pkt_base_d   = 16'd0;
          pkt_len_d    = start_len;
          toggle_d     = 1'b1;
          zlp_pkt_d    = 1'b0;
          zlp_needed_d = (total != 16'd0) && (total[MPS_W-1:0] == '0) && (total < w_length);
          if (total == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_FETCH;
            rd_pend_d = 1'b1;
            rd_last_d = (total == 16'd1);
            rd_off_d  = 16'd1;
          end
        end
      end
      ST_FETCH: begin
        if (rd_pend_q) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (pop && out_last_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (zlp_pkt_q) begin
          if (pkt_ack) begin
            toggle_d     = ~toggle_q;
            zlp_needed_d = 1'b0;
            state_d      = ST_DONE;
          end else if (pkt_retry) begin
            state_d     = ST_ZLP;
            out_valid_d = 1'b1;
            out_zlp_d   = 1'b1;
            out_last_d  = 1'b1;
          end
        end else if (pkt_ack) begin
          pkt_base_d  = pkt_end;
          remaining_d = rem_after;
          toggle_d    = ~toggle_q;
          if (rem_after != 16'd0) begin
            pkt_len_d = next_len;
            rd_off_d  = pkt_end;
            state_d   = ST_SEND;
          end else if (zlp_needed_q) begin
            state_d     = ST_ZLP;
            zlp_pkt_d   = 1'b1;
            out_valid_d = 1'b1;
            out_zlp_d   = 1'b1;
            out_last_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (pkt_retry) begin
          rd_off_d = pkt_base_q;
          state_d  = ST_SEND;
        end
      end
      ST_ZLP: begin
        if (pop) begin
          out_valid_d = 1'b0;
          out_zlp_d   = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      out_zlp_d    = 1'b0;
      skid_valid_d = 1'b0;
      rd_pend_d    = 1'b0;
      toggle_d     = 1'b1;
      zlp_pkt_d    = 1'b0;
    end
  end

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      remaining_q  <= 16'd0;
      pkt_base_q   <= 16'd0;
      pkt_len_q    <= 16'd0;
      rd_off_q     <= 16'd0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 8'd0;
      skid_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      out_last_q   <= 1'b0;
      out_zlp_q    <= 1'b0;
      toggle_q     <= 1'b1;
      zlp_needed_q <= 1'b0;
      zlp_pkt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      remaining_q  <= remaining_d;
      pkt_base_q   <= pkt_base_d;
      pkt_len_q    <= pkt_len_d;
      rd_off_q     <= rd_off_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_zlp_q    <= out_zlp_d;
      toggle_q     <= toggle_d;
      zlp_needed_q <= zlp_needed_d;
      zlp_pkt_q    <= zlp_pkt_d;
    end
  end

  assign in_valid    = out_valid_q;
  assign in_data     = out_data_q;
  assign in_last     = out_last_q;
  assign in_zlp      = out_zlp_q;
  assign data_toggle = toggle_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_SEND) ||
                       (state_q == ST_WAIT) || (state_q == ST_ZLP);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_usb_ep0_descriptor_streamer.sv
// tb/tb_usb_ep0_descriptor_streamer.sv - table-driven bench for usb_ep0_descriptor_streamer
// Three instances (max packet 64, 8, 16) share one clock and a synthetic ROM pattern.
module tb_usb_ep0_descriptor_streamer;

  typedef struct packed {
    int              inst;
    int              base;
    int              dlen;
    int              wlen;
    int              retry_pkt;
    int              both_pkt;
    int              stall;
    int              npkt;
    logic [3:0][7:0] plen;
    logic [3:0]      ptog;
  } vec_t;

  logic clk48 = 1'b0;
  logic rstn  = 1'b0;
  always #5 clk48 = ~clk48;

  logic [2:0]  start_s, abort_s, in_ready_s, ack_s, retry_s;
  logic [8:0]  base_s [3];
  logic [15:0] dlen_s [3];
  logic [15:0] wlen_s [3];
  wire  [8:0]  rom_addr_w [3];
  wire  [7:0]  in_data_w [3];
  wire  [2:0]  in_valid_w, in_last_w, in_zlp_w, tog_w, busy_w, done_w;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs [10];

  function automatic logic [7:0] rom_val(input int a);
    int x;
    x = a & 511;
    return 8'((x * 37) + ((x >> 8) * 101) + 5);
  endfunction

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int MPS = (g == 0) ? 64 : ((g == 1) ? 8 : 16);
    logic [7:0] rom_q;
    always @(posedge clk48) rom_q <= rom_val(int'(rom_addr_w[g]));
    usb_ep0_descriptor_streamer #(.MAX_PACKET_SIZE(MPS), .ROM_ADDR_W(9)) u_dut (
      .clk48      (clk48),
      .rstn       (rstn),
      .start      (start_s[g]),
      .abort      (abort_s[g]),
      .base_addr  (base_s[g]),
      .desc_len   (dlen_s[g]),
      .w_length   (wlen_s[g]),
      .rom_addr   (rom_addr_w[g]),
      .rom_data   (rom_q),
      .in_valid   (in_valid_w[g]),
      .in_data    (in_data_w[g]),
      .in_last    (in_last_w[g]),
      .in_zlp     (in_zlp_w[g]),
      .in_ready   (in_ready_s[g]),
      .pkt_ack    (ack_s[g]),
      .pkt_retry  (retry_s[g]),
      .data_toggle(tog_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g])
    );
  end

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  function automatic vec_t mk(input int inst, input int base, input int dlen, input int wlen,
                              input int rp, input int bp, input int st, input int np,
                              input int l0, input int l1, input int l2, input int l3,
                              input logic [3:0] tg);
    vec_t v;
    v.inst = inst; v.base = base; v.dlen = dlen; v.wlen = wlen;
    v.retry_pkt = rp; v.both_pkt = bp; v.stall = st; v.npkt = np;
    v.plen[0] = 8'(l0); v.plen[1] = 8'(l1); v.plen[2] = 8'(l2); v.plen[3] = 8'(l3);
    v.ptog = tg;
    return v;
  endfunction

  // Acts as the host plus IN buffer: consumes beats, checks them, then ACKs or retries.
  task automatic run_vec(input vec_t v);
    int idx, p, cnt, pstart, exp_done, first_v, pkt_first, resp_dly, rc;
    bit resp_pend, retried, got_done, prev_stall, rdy;
    logic [7:0] prev_data;
    logic prev_last, prev_zlp;
    idx = v.inst;
    @(negedge clk48);
    base_s[idx] = 9'(v.base);
    dlen_s[idx] = 16'(v.dlen);
    wlen_s[idx] = 16'(v.wlen);
    start_s[idx] = 1'b1;
    exp_done = (v.npkt == 0) ? 1 : -1;
    p = 0; cnt = 0; pstart = 0; first_v = -1; pkt_first = 0; resp_dly = 0;
    resp_pend = 0; retried = 0; got_done = 0; prev_stall = 0;
    prev_data = 8'd0; prev_last = 1'b0; prev_zlp = 1'b0;
    for (int t = 0; t < 3000 && !got_done; t++) begin
      @(negedge clk48);
      rc = t + 1;
      start_s[idx] = 1'b0; ack_s[idx] = 1'b0; retry_s[idx] = 1'b0;
      if (t == 0 && v.npkt > 0) chk("busy_after_start", int'(busy_w[idx]), 1);
      if (prev_stall) begin
        chk("hold_valid", int'(in_valid_w[idx]), 1);
        chk("hold_data", int'(in_data_w[idx]), int'(prev_data));
        chk("hold_last", int'(in_last_w[idx]), int'(prev_last));
        chk("hold_zlp", int'(in_zlp_w[idx]), int'(prev_zlp));
      end
      if (done_w[idx]) begin
        got_done = 1;
        chk("done_cycle", rc, exp_done);
        chk("done_busy", int'(busy_w[idx]), 0);
        chk("done_pkts", p, v.npkt);
      end
      if (in_valid_w[idx] && first_v < 0) first_v = rc;
      if (resp_pend) begin
        if (resp_dly == 0) begin
          resp_pend = 0;
          if (p == v.retry_pkt && !retried) begin
            retry_s[idx] = 1'b1; retried = 1; cnt = 0;
          end else begin
            ack_s[idx] = 1'b1;
            if (p == v.both_pkt) retry_s[idx] = 1'b1;
            pstart += int'(v.plen[p]);
            p++; cnt = 0;
            if (p == v.npkt) exp_done = rc + 1;
          end
        end else begin
          resp_dly--;
        end
      end
      rdy = (v.stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_ready_s[idx] = rdy;
      prev_stall = in_valid_w[idx] && !rdy;
      prev_data = in_data_w[idx]; prev_last = in_last_w[idx]; prev_zlp = in_zlp_w[idx];
      if (in_valid_w[idx] && rdy) begin
        chk("beat_in_range", int'(p < v.npkt), 1);
        if (p < v.npkt) begin
          chk("beat_zlp", int'(in_zlp_w[idx]), int'(v.plen[p] == 8'd0));
          if (in_zlp_w[idx]) begin
            chk("zlp_last", int'(in_last_w[idx]), 1);
            chk("zlp_toggle", int'(tog_w[idx]), int'(v.ptog[p]));
          end else begin
            if (cnt == 0) pkt_first = rc;
            chk("byte", int'(in_data_w[idx]), int'(rom_val(v.base + pstart + cnt)));
            cnt++;
            chk("last_flag", int'(in_last_w[idx]), int'(cnt == int'(v.plen[p])));
            if (in_last_w[idx]) begin
              chk("pkt_len", cnt, int'(v.plen[p]));
              chk("pkt_toggle", int'(tog_w[idx]), int'(v.ptog[p]));
              if (v.stall == 0) chk("no_bubble", rc - pkt_first, cnt - 1);
            end
          end
          if (in_last_w[idx]) begin
            resp_pend = 1;
            resp_dly = p % 2;
          end
        end
      end
    end
    chk("done_seen", int'(got_done), 1);
    if (v.npkt > 0) chk("first_valid_latency", int'(first_v >= 0 && first_v <= 2), 1);
    else chk("no_beats", int'(first_v < 0), 1);
    in_ready_s[idx] = 1'b1;
    @(negedge clk48);
    chk("done_pulse_width", int'(done_w[idx]), 0);
    chk("idle_busy", int'(busy_w[idx]), 0);
  endtask

  initial begin
    int beats;
    start_s = '0; abort_s = '0; ack_s = '0; retry_s = '0; in_ready_s = 3'b111;
    for (int i = 0; i < 3; i++) begin
      base_s[i] = '0; dlen_s[i] = '0; wlen_s[i] = '0;
    end

    //        inst base dlen wlen rp  bp  st np  l0  l1  l2  l3  toggles(bit i = pkt i)
    vecs[0] = mk(0, 16,  18,  64, -1, -1, 0, 1, 18,  0,  0,  0, 4'b0001);
    vecs[1] = mk(1,  0,  18,  64, -1, -1, 0, 3,  8,  8,  2,  0, 4'b0101);
    vecs[2] = mk(2, 100, 32, 255, -1, -1, 0, 3, 16, 16,  0,  0, 4'b0101);
    vecs[3] = mk(1, 40,  18,  64,  1, -1, 0, 3,  8,  8,  2,  0, 4'b0101);
    vecs[4] = mk(1, 40,  18,  64, -1,  1, 0, 3,  8,  8,  2,  0, 4'b0101);
    vecs[5] = mk(0, 16,  18,   0, -1, -1, 0, 0,  0,  0,  0,  0, 4'b0000);
    vecs[6] = mk(0, 200, 40,  20, -1, -1, 0, 1, 20,  0,  0,  0, 4'b0001);
    vecs[7] = mk(1, 500, 24,  24, -1, -1, 1, 3,  8,  8,  8,  0, 4'b0101);
    vecs[8] = mk(2, 300, 50,  64,  2, -1, 1, 4, 16, 16, 16,  2, 4'b0101);
    vecs[9] = mk(0,  0,  64, 100, -1, -1, 0, 2, 64,  0,  0,  0, 4'b0001);

    repeat (3) @(negedge clk48);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_valid", int'(in_valid_w[i]), 0);
      chk("rst_busy", int'(busy_w[i]), 0);
      chk("rst_done", int'(done_w[i]), 0);
      chk("rst_toggle", int'(tog_w[i]), 1);
      chk("rst_rom_addr", int'(rom_addr_w[i]), 0);
    end
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // abort in the middle of a packet, then a clean transfer
    @(negedge clk48);
    base_s[1] = 9'd0; dlen_s[1] = 16'd18; wlen_s[1] = 16'd64; start_s[1] = 1'b1;
    beats = 0;
    for (int t = 0; t < 20 && beats < 3; t++) begin
      @(negedge clk48);
      start_s[1] = 1'b0;
      if (in_valid_w[1] && in_ready_s[1]) beats++;
    end
    chk("abort_setup_beats", beats, 3);
    abort_s[1] = 1'b1;
    @(negedge clk48);
    abort_s[1] = 1'b0;
    chk("abort_in_valid", int'(in_valid_w[1]), 0);
    chk("abort_busy", int'(busy_w[1]), 0);
    chk("abort_toggle", int'(tog_w[1]), 1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk48);
      chk("abort_no_done", int'(done_w[1]), 0);
      chk("abort_stays_idle", int'(in_valid_w[1]), 0);
    end
    run_vec(vecs[1]);

    // start and abort together: start is dropped
    @(negedge clk48);
    base_s[0] = 9'd0; dlen_s[0] = 16'd18; wlen_s[0] = 16'd64;
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(negedge clk48);
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("start_abort_busy", int'(busy_w[0]), 0);
      chk("start_abort_valid", int'(in_valid_w[0]), 0);
      chk("start_abort_done", int'(done_w[0]), 0);
      @(negedge clk48);
    end

    // asynchronous reset while a byte is held under backpressure
    in_ready_s[0] = 1'b0;
    base_s[0] = 9'd8; dlen_s[0] = 16'd64; wlen_s[0] = 16'd64; start_s[0] = 1'b1;
    beats = 0;
    for (int t = 0; t < 6 && beats == 0; t++) begin
      @(negedge clk48);
      start_s[0] = 1'b0;
      if (in_valid_w[0]) beats = 1;
    end
    chk("rst_setup_valid", int'(in_valid_w[0]), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_in_valid", int'(in_valid_w[0]), 0);
    chk("arst_in_data", int'(in_data_w[0]), 0);
    chk("arst_in_last", int'(in_last_w[0]), 0);
    chk("arst_in_zlp", int'(in_zlp_w[0]), 0);
    chk("arst_rom_addr", int'(rom_addr_w[0]), 0);
    chk("arst_toggle", int'(tog_w[0]), 1);
    chk("arst_busy", int'(busy_w[0]), 0);
    chk("arst_done", int'(done_w[0]), 0);
    @(negedge clk48);
    rstn = 1'b1;
    in_ready_s[0] = 1'b1;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
